memory_range_tracker_mc: RTL and testbench

Multi-channel, parametrised successor to the single-port write-range tracker. It watches up to NUM_CH memory write ports in the computer system and records the lowest and highest byte address touched inside a configured address window, using byte-strobe precision. It also counts accepted and out-of-window writes. A snapshot/acknowledge handshake lets the debug/dump unit take a consistent copy of the range, optionally starting a new tracking epoch atomically.

---
 rtl/mrt_pkg.sv | 38 +++
 rtl/mrt_strb_span.sv | 36 +++
 rtl/memory_range_tracker_mc.sv | 137 +++++++++++++
 tb/tb_memory_range_tracker_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mrt_pkg.sv
// Shared types and helpers for the multi-channel memory range tracker.
package mrt_pkg;

  typedef enum logic [0:0] {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_t;

  localparam int MAX_STRB = 64;

  // Index of the lowest (highest=0) or highest (highest=1) set strobe within width.
  function automatic int strb_index(input logic [MAX_STRB-1:0] strb, input int width,
                                    input logic highest);
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_STRB; i++) begin
      if (i < width && strb[i] && (highest || !found)) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max_val);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
  endfunction

  function automatic logic addr_lt(input logic [63:0] a, input logic [63:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/mrt_strb_span.sv
// Per-channel byte span: lowest/highest strobed byte address and window test.
module mrt_strb_span
  import mrt_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                STRB_W    = 4,
  parameter logic [ADDR_W-1:0] WIN_BASE  = '0,
  parameter logic [ADDR_W-1:0] WIN_LIMIT = '1
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [STRB_W-1:0] strb,
  output logic              active,
  output logic              in_win,
  output logic              out_win,
  output logic [ADDR_W-1:0] lo,
  output logic [ADDR_W-1:0] hi
);

  localparam int                OFF_W    = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRB_W - 1);

  logic [OFF_W-1:0] lo_idx;
  logic [OFF_W-1:0] hi_idx;

  assign lo_idx = OFF_W'(strb_index(MAX_STRB'(strb), STRB_W, 1'b0));
  assign hi_idx = OFF_W'(strb_index(MAX_STRB'(strb), STRB_W, 1'b1));

  assign lo = (addr & ~OFF_MASK) | ADDR_W'(lo_idx);
  assign hi = (addr & ~OFF_MASK) | ADDR_W'(hi_idx);

  assign active  = wr_en && (|strb);
  assign in_win  = active && !addr_lt(64'(lo), 64'(WIN_BASE)) && !addr_lt(64'(WIN_LIMIT), 64'(hi));
  assign out_win = active && !in_win;

endmodule

// File: rtl/memory_range_tracker_mc.sv
// Multi-channel write-range tracker: merges per-channel byte spans into a live
// epoch and offers a snapshot/acknowledge handshake for the dump unit.
//
// state     | meaning
// SNAP_IDLE | no unconsumed snapshot; the next snap_req is captured
// SNAP_HOLD | snapshot registers frozen until snap_ack
module memory_range_tracker_mc
  import mrt_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                NUM_CH        = 2,
  parameter int                STRB_W        = 4,
  parameter int                CNT_W         = 16,
  parameter logic [ADDR_W-1:0] WIN_BASE      = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] WIN_LIMIT     = ADDR_W'(32'h0000_0FFF),
  parameter bit                CLEAR_ON_SNAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     soft_reset_ni,
  input  logic                     clear_i,
  input  logic [NUM_CH-1:0]        wr_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_CH*STRB_W-1:0] wr_strb_i,
  output logic [ADDR_W-1:0]        min_addr_o,
  output logic [ADDR_W-1:0]        max_addr_o,
  output logic                     range_valid_o,
  output logic [CNT_W-1:0]         wr_count_o,
  output logic [CNT_W-1:0]         oow_count_o,
  input  logic                     snap_req_i,
  input  logic                     snap_ack_i,
  output logic                     snap_valid_o,
  output logic [ADDR_W-1:0]        snap_min_o,
  output logic [ADDR_W-1:0]        snap_max_o,
  output logic                     snap_range_valid_o,
  output logic [CNT_W-1:0]         snap_count_o,
  output logic                     snap_overrun_o
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] ch_in;
  logic [NUM_CH-1:0] ch_oow;
  logic [ADDR_W-1:0] ch_lo [NUM_CH];
  logic [ADDR_W-1:0] ch_hi [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_span
    mrt_strb_span #(
      .ADDR_W   (ADDR_W),
      .STRB_W   (STRB_W),
      .WIN_BASE (WIN_BASE),
      .WIN_LIMIT(WIN_LIMIT)
    ) u_span (
      .wr_en  (wr_en_i[k]),
      .addr   (wr_addr_i[k*ADDR_W +: ADDR_W]),
      .strb   (wr_strb_i[k*STRB_W +: STRB_W]),
      .active (ch_active[k]),
      .in_win (ch_in[k]),
      .out_win(ch_oow[k]),
      .lo     (ch_lo[k]),
      .hi     (ch_hi[k])
    );
  end

  snap_state_t       state_q, state_d;
  logic              snap_accept;
  logic              restart;
  logic [ADDR_W-1:0] min_d, max_d;
  logic              valid_d;
  logic [31:0]       in_pop, oow_pop;
  logic [CNT_W-1:0]  wr_d, oow_d;

  assign snap_accept = (state_q == SNAP_IDLE) && snap_req_i;
  // An accepted snapshot may open a fresh epoch exactly like clear_i does.
  assign restart     = clear_i || (snap_accept && CLEAR_ON_SNAP);

  always_comb begin
    min_d   = restart ? '1 : min_addr_o;
    max_d   = restart ? '0 : max_addr_o;
    valid_d = restart ? 1'b0 : range_valid_o;
    in_pop  = '0;
    oow_pop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_in[k]) begin
        if (ch_lo[k] < min_d) min_d = ch_lo[k];
        if (ch_hi[k] > max_d) max_d = ch_hi[k];
        valid_d = 1'b1;
        in_pop  = in_pop + 32'd1;
      end
      if (ch_oow[k]) oow_pop = oow_pop + 32'd1;
    end
    wr_d  = CNT_W'(sat_add(restart ? 64'd0 : 64'(wr_count_o), 64'(in_pop), CNT_MAX));
    oow_d = CNT_W'(sat_add(restart ? 64'd0 : 64'(oow_count_o), 64'(oow_pop), CNT_MAX));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SNAP_IDLE: if (snap_req_i) state_d = SNAP_HOLD;
      SNAP_HOLD: if (snap_ack_i) state_d = SNAP_IDLE;
      default:   state_d = SNAP_IDLE;
    endcase
  end

  assign snap_valid_o = (state_q == SNAP_HOLD);

  always_ff @(posedge clk) begin
    if (!soft_reset_ni) begin
      state_q            <= SNAP_IDLE;
      min_addr_o         <= '1;
      max_addr_o         <= '0;
      range_valid_o      <= 1'b0;
      wr_count_o         <= '0;
      oow_count_o        <= '0;
      snap_min_o         <= '1;
      snap_max_o         <= '0;
      snap_range_valid_o <= 1'b0;
      snap_count_o       <= '0;
      snap_overrun_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      min_addr_o    <= min_d;
      max_addr_o    <= max_d;
      range_valid_o <= valid_d;
      wr_count_o    <= wr_d;
      oow_count_o   <= oow_d;
      if (snap_accept) begin
        snap_min_o         <= min_addr_o;
        snap_max_o         <= max_addr_o;
        snap_range_valid_o <= range_valid_o;
        snap_count_o       <= wr_count_o;
      end
      if (state_q == SNAP_HOLD && snap_req_i) snap_overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_range_tracker_mc.sv
// Bench for memory_range_tracker_mc: two instances (defaults, and CNT_W=2 with
// CLEAR_ON_SNAP=0) checked every cycle against a byte-level behavioural model.
module tb_memory_range_tracker_mc;
  localparam int AW = 32;
  localparam int NC = 2;
  localparam int SW = 4;
  localparam longint WB = 0;
  localparam longint WL = 'hFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, req = 1'b0, ack = 1'b0;
  logic [NC-1:0]    en = '0;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*SW-1:0] strb = '0;

  logic [AW-1:0] min_a, max_a, smin_a, smax_a, min_b, max_b, smin_b, smax_b;
  logic          val_a, sval_a, srv_a, ovr_a, val_b, sval_b, srv_b, ovr_b;
  logic [15:0]   wr_a, oow_a, scnt_a;
  logic [1:0]    wr_b, oow_b, scnt_b;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  memory_range_tracker_mc dut_a (
    .clk(clk), .soft_reset_ni(rst_n), .clear_i(clear), .wr_en_i(en), .wr_addr_i(addr),
    .wr_strb_i(strb), .min_addr_o(min_a), .max_addr_o(max_a), .range_valid_o(val_a),
    .wr_count_o(wr_a), .oow_count_o(oow_a), .snap_req_i(req), .snap_ack_i(ack),
    .snap_valid_o(sval_a), .snap_min_o(smin_a), .snap_max_o(smax_a),
    .snap_range_valid_o(srv_a), .snap_count_o(scnt_a), .snap_overrun_o(ovr_a));

  memory_range_tracker_mc #(.CNT_W(2), .CLEAR_ON_SNAP(1'b0)) dut_b (
    .clk(clk), .soft_reset_ni(rst_n), .clear_i(clear), .wr_en_i(en), .wr_addr_i(addr),
    .wr_strb_i(strb), .min_addr_o(min_b), .max_addr_o(max_b), .range_valid_o(val_b),
    .wr_count_o(wr_b), .oow_count_o(oow_b), .snap_req_i(req), .snap_ack_i(ack),
    .snap_valid_o(sval_b), .snap_min_o(smin_b), .snap_max_o(smax_b),
    .snap_range_valid_o(srv_b), .snap_count_o(scnt_b), .snap_overrun_o(ovr_b));

  // Model state per instance; counts kept unbounded and saturated on compare.
  longint m_min[2], m_max[2], s_min[2], s_max[2];
  int     m_wr[2], m_oow[2], s_cnt[2];
  bit     m_val[2], s_val[2], m_hold[2], m_ovr[2];
  int     sat_max[2] = '{65535, 3};
  bit     cos[2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    bit take;
    longint lo, hi;
    logic [31:0] base;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_min[i] = 'hFFFF_FFFF; m_max[i] = 0; m_val[i] = 0; m_wr[i] = 0; m_oow[i] = 0;
        s_min[i] = 'hFFFF_FFFF; s_max[i] = 0; s_val[i] = 0; s_cnt[i] = 0;
        m_hold[i] = 0; m_ovr[i] = 0;
      end else begin
        take = !m_hold[i] && req;
        if (take) begin
          s_min[i] = m_min[i]; s_max[i] = m_max[i]; s_val[i] = m_val[i]; s_cnt[i] = m_wr[i];
          m_hold[i] = 1;
        end else if (m_hold[i]) begin
          if (req) m_ovr[i] = 1;
          if (ack) m_hold[i] = 0;
        end
        if (clear || (take && cos[i])) begin
          m_min[i] = 'hFFFF_FFFF; m_max[i] = 0; m_val[i] = 0; m_wr[i] = 0; m_oow[i] = 0;
        end
        for (int k = 0; k < NC; k++) begin
          lo = -1; hi = -1;
          base = addr[k*AW +: AW];
          base[1:0] = 2'b00;
          for (int b = 0; b < SW; b++) begin
            if (en[k] && strb[k*SW + b]) begin
              if (lo < 0) lo = longint'(base) + b;
              hi = longint'(base) + b;
            end
          end
          if (lo >= 0) begin
            if (lo >= WB && hi <= WL) begin
              if (lo < m_min[i]) m_min[i] = lo;
              if (hi > m_max[i]) m_max[i] = hi;
              m_val[i] = 1; m_wr[i]++;
            end else begin
              m_oow[i]++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a.min", 64'(min_a), 64'(m_min[0]));
      chk("a.max", 64'(max_a), 64'(m_max[0]));
      chk("a.valid", 64'(val_a), 64'(m_val[0]));
      chk("a.wr", 64'(wr_a), 64'(sat(m_wr[0], sat_max[0])));
      chk("a.oow", 64'(oow_a), 64'(sat(m_oow[0], sat_max[0])));
      chk("a.snap_valid", 64'(sval_a), 64'(m_hold[0]));
      chk("a.snap_min", 64'(smin_a), 64'(s_min[0]));
      chk("a.snap_max", 64'(smax_a), 64'(s_max[0]));
      chk("a.snap_rv", 64'(srv_a), 64'(s_val[0]));
      chk("a.snap_cnt", 64'(scnt_a), 64'(sat(s_cnt[0], sat_max[0])));
      chk("a.overrun", 64'(ovr_a), 64'(m_ovr[0]));
      chk("b.min", 64'(min_b), 64'(m_min[1]));
      chk("b.max", 64'(max_b), 64'(m_max[1]));
      chk("b.valid", 64'(val_b), 64'(m_val[1]));
      chk("b.wr", 64'(wr_b), 64'(sat(m_wr[1], sat_max[1])));
      chk("b.oow", 64'(oow_b), 64'(sat(m_oow[1], sat_max[1])));
      chk("b.snap_valid", 64'(sval_b), 64'(m_hold[1]));
      chk("b.snap_min", 64'(smin_b), 64'(s_min[1]));
      chk("b.snap_max", 64'(smax_b), 64'(s_max[1]));
      chk("b.snap_rv", 64'(srv_b), 64'(s_val[1]));
      chk("b.snap_cnt", 64'(scnt_b), 64'(sat(s_cnt[1], sat_max[1])));
      chk("b.overrun", 64'(ovr_b), 64'(m_ovr[1]));
    end
  end

  task automatic step(input logic [1:0] e, input logic [31:0] a0, input logic [3:0] s0,
                      input logic [31:0] a1, input logic [3:0] s1,
                      input logic c, input logic r, input logic k);
    en = e; addr = {a1, a0}; strb = {s1, s0}; clear = c; req = r; ack = k;
    @(posedge clk); #1;
    en = '0; addr = '0; strb = '0; clear = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    chk("lit_rst_min", 64'(min_a), 64'hFFFF_FFFF);
    chk("lit_rst_max", 64'(max_a), 64'h0);
    chk("lit_rst_valid", 64'(val_a), 64'h0);
    chk("lit_rst_cnt", 64'({wr_a, oow_a}), 64'h0);
    chk("lit_rst_snapv", 64'(sval_a), 64'h0);

    step(2'b01, 32'h100, 4'b1100, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_byte_min", 64'(min_a), 64'h102);
    chk("lit_byte_max", 64'(max_a), 64'h103);
    chk("lit_byte_valid", 64'(val_a), 64'h1);
    chk("lit_byte_wr", 64'(wr_a), 64'h1);

    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("lit_clr_min", 64'(min_a), 64'hFFFF_FFFF);
    chk("lit_clr_wr", 64'(wr_a), 64'h0);

    step(2'b11, 32'h200, 4'b0001, 32'h040, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_dual_min", 64'(min_a), 64'h040);
    chk("lit_dual_max", 64'(max_a), 64'h200);
    chk("lit_dual_wr", 64'(wr_a), 64'h2);

    step(2'b01, 32'h300, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_nostrb_max", 64'(max_a), 64'h200);
    chk("lit_nostrb_wr", 64'(wr_a), 64'h2);

    step(2'b01, 32'h300, 4'b1111, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("lit_snap_valid", 64'(sval_a), 64'h1);
    chk("lit_snap_min", 64'(smin_a), 64'h040);
    chk("lit_snap_max", 64'(smax_a), 64'h200);
    chk("lit_snap_cnt", 64'(scnt_a), 64'h2);
    chk("lit_snap_live_min", 64'(min_a), 64'h300);
    chk("lit_snap_live_max", 64'(max_a), 64'h303);
    chk("lit_snap_live_wr", 64'(wr_a), 64'h1);
    chk("lit_b_live_min", 64'(min_b), 64'h040);
    chk("lit_b_live_max", 64'(max_b), 64'h303);

    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("lit_overrun", 64'(ovr_a), 64'h1);
    chk("lit_overrun_min", 64'(smin_a), 64'h040);

    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("lit_ack_valid", 64'(sval_a), 64'h0);
    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("lit_idle_ack", 64'(sval_a), 64'h0);

    step(2'b10, 32'h0, 4'b0000, 32'h2000, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_oow_cnt", 64'(oow_a), 64'h1);
    chk("lit_oow_min", 64'(min_a), 64'h300);
    chk("lit_oow_wr", 64'(wr_a), 64'h1);

    step(2'b01, 32'hFFC, 4'b1111, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_edge_max", 64'(max_a), 64'hFFF);

    step(2'b01, 32'h010, 4'b0010, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("lit_clrmerge_min", 64'(min_a), 64'h011);
    chk("lit_clrmerge_max", 64'(max_a), 64'h011);
    chk("lit_clrmerge_wr", 64'(wr_a), 64'h1);

    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step(2'b01, 32'h20, 4'b0001, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_sat_b", 64'(wr_b), 64'h3);
    chk("lit_sat_a", 64'(wr_a), 64'h5);

    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("lit_hold", 64'(sval_a), 64'h1);
    rst_n = 1'b0;
    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_hrst_snapv", 64'(sval_a), 64'h0);
    chk("lit_hrst_snapmin", 64'(smin_a), 64'hFFFF_FFFF);
    chk("lit_hrst_min", 64'(min_a), 64'hFFFF_FFFF);
    chk("lit_hrst_wr", 64'(wr_a), 64'h0);
    rst_n = 1'b1;
    step(2'b00, 32'h0, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
